// File: rtl/seq_det_pkg.sv
// Shared constants, types and helpers for the parametrised serial pattern detector.
package seq_det_pkg;

  localparam int         DEF_MAX_W = 8;
  localparam logic [7:0] DEF_PAT_C = 8'b0001_1011;
  localparam int         DEF_LEN_C = 5;
  localparam bit         DEF_OVL_C = 1'b1;

  // Width of a field that must hold any length from 0 up to max_w inclusive.
  function automatic int len_w(input int max_w);
    return $clog2(max_w + 1);
  endfunction

  localparam int DEF_LEN_W = len_w(DEF_MAX_W);

  // Configuration record at the default pattern width.
  typedef struct packed {
    logic [DEF_MAX_W-1:0] pat;
    logic [DEF_LEN_W-1:0] len;
    logic                 ovl;
  } cfg_t;

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment yields 1.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear first, then increment, never wrapping past all-ones.
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = inc ? W'(1) : '0;
    end else if (inc && (q_q != '1)) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/seq_detector_param.sv
// Parametrised serial bit-pattern detector with runtime-loadable pattern,
// length and overlap mode, plus a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               MAX_W   = 8,
  parameter logic [MAX_W-1:0] DEF_PAT = MAX_W'(DEF_PAT_C),
  parameter int               DEF_LEN = DEF_LEN_C,
  parameter bit               DEF_OVL = DEF_OVL_C,
  parameter int               CNT_W   = 8,
  localparam int              LEN_W   = len_w(MAX_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_vld,
  input  logic             cfg_load,
  input  logic [MAX_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(DEF_LEN);

  // Length 0 is meaningless and lengths beyond the history cannot be checked.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] n);
    if (n == '0)          return LEN_W'(1);
    if (int'(n) > MAX_W)  return LEN_W'(MAX_W);
    return n;
  endfunction

  // Ones in the low n bit positions.
  function automatic logic [MAX_W-1:0] mask_of(input logic [LEN_W-1:0] n);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  logic [MAX_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [MAX_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [MAX_W-1:0] mask_q, mask_d;
  logic             out_q, out_d;

  logic [MAX_W-1:0] hist_shift;
  logic [LEN_W-1:0] fill_inc;
  logic [LEN_W-1:0] cfg_len_c;
  logic             hit;
  logic             match;

  assign hist_shift = {hist_q[MAX_W-2:0], x};
  assign fill_inc   = (int'(fill_q) >= MAX_W) ? fill_q : fill_q + LEN_W'(1);
  assign cfg_len_c  = clamp_len(cfg_len);
  // The fill check suppresses matches against the zeroed history after reset/load.
  assign hit        = (fill_inc >= len_q) && (((hist_shift ^ pat_q) & mask_q) == '0);

  // Next-state: a config load wins over sampling and drops any partial match.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    mask_d = mask_q;
    out_d  = 1'b0;
    match  = 1'b0;
    if (cfg_load) begin
      pat_d  = cfg_pat;
      len_d  = cfg_len_c;
      ovl_d  = cfg_ovl;
      mask_d = mask_of(cfg_len_c);
      hist_d = '0;
      fill_d = '0;
    end else if (x_vld) begin
      hist_d = hist_shift;
      match  = hit;
      out_d  = hit;
      // Non-overlapping mode restarts the fill so a full fresh pattern is needed.
      fill_d = (hit && !ovl_q) ? '0 : fill_inc;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= DEF_PAT;
      len_q  <= RST_LEN;
      ovl_q  <= DEF_OVL;
      mask_q <= mask_of(RST_LEN);
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      mask_q <= mask_d;
      out_q  <= out_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (match),
    .q   (match_cnt)
  );

  assign out = out_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param with a bit-queue reference model.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       x, x_vld, cfg_load, cfg_ovl, cnt_clr;
  logic [7:0] cfg_pat;
  logic [3:0] cfg_len;
  logic       out;
  logic [7:0] match_cnt;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_vld     (x_vld),
    .cfg_load  (cfg_load),
    .cfg_pat   (cfg_pat),
    .cfg_len   (cfg_len),
    .cfg_ovl   (cfg_ovl),
    .cnt_clr   (cnt_clr),
    .out       (out),
    .match_cnt (match_cnt)
  );

  typedef struct {
    logic       o;
    logic [7:0] c;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: bits received since the stream (re)started, oldest first.
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         bits[$];
  int         m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pat = 8'h1B;
    m_len = 5;
    m_ovl = 1'b1;
    bits.delete();
    m_cnt = 0;
  endfunction

  task automatic step(input bit xv, input bit xb, input bit ld, input logic [7:0] pat,
                      input logic [3:0] len, input bit ovl, input bit clr);
    bit   hit;
    exp_t e;
    @(negedge clk);
    x_vld = xv; x = xb; cfg_load = ld; cfg_pat = pat; cfg_len = len;
    cfg_ovl = ovl; cnt_clr = clr;
    hit = 1'b0;
    if (ld) begin
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((len > 8) ? 8 : int'(len));
      m_ovl = ovl;
      bits.delete();
    end else if (xv) begin
      bits.push_back(xb);
      if (bits.size() > 8) void'(bits.pop_front());
      if (bits.size() >= m_len) begin
        hit = 1'b1;
        // Most recent bit pairs with pat[0]; the oldest of the window with pat[len-1].
        for (int k = 0; k < m_len; k++)
          if (bits[bits.size() - 1 - k] != m_pat[k]) hit = 1'b0;
      end
      if (hit && !m_ovl) bits.delete();
    end
    if (clr) m_cnt = 0;
    if (hit && m_cnt < 255) m_cnt++;
    e.o = hit;
    e.c = m_cnt[7:0];
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic bit_in(input bit b);
    step(1'b1, b, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic gap();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ovl, input bit clr);
    step(1'b0, 1'b0, 1'b1, pat, len, ovl, clr);
  endtask

  // Sends n bits MSB first; pulses[i] is out after bit i+1.
  task automatic send(input logic [15:0] b, input int n, output logic [15:0] pulses);
    pulses = '0;
    for (int i = 0; i < n; i++) begin
      bit_in(b[n-1-i]);
      pulses[i] = out;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    x_vld = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; x = 1'b0;
    rst = 1'b1;
    #2;
    chk("async_rst_out", out, 0);
    chk("async_rst_cnt", match_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare every sampled edge against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_out", out, e.o);
        chk("sb_cnt", match_cnt, e.c);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p;
    int          r;
    logic [3:0]  rl;
    rst = 1'b1; x = 1'b0; x_vld = 1'b0; cfg_load = 1'b0; cfg_pat = '0;
    cfg_len = '0; cfg_ovl = 1'b0; cnt_clr = 1'b0;
    model_reset();
    #12;
    chk("reset_out", out, 0);
    chk("reset_cnt", match_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Default overlapping 11011.
    send(16'b11011011011, 11, p);
    chk("ovl_pulses", p, 16'h0490);
    chk("ovl_cnt", match_cnt, 3);

    // Non-overlapping 11011.
    load(8'h1B, 4'd5, 1'b0, 1'b1);
    send(16'b11011011011, 11, p);
    chk("novl_pulses", p, 16'h0410);
    chk("novl_cnt", match_cnt, 2);

    // Bit order.
    load(8'h0D, 4'd4, 1'b1, 1'b1);
    send(16'b1011, 4, p);
    chk("order_1011", p, 16'h0000);
    load(8'h0D, 4'd4, 1'b1, 1'b1);
    send(16'b1101, 4, p);
    chk("order_1101", p, 16'h0008);

    // Gaps in x_vld.
    load(8'h1B, 4'd5, 1'b1, 1'b1);
    bit_in(1); bit_in(1);
    gap(); gap(); gap();
    bit_in(0); bit_in(1); bit_in(1);
    chk("gap_out", out, 1);
    chk("gap_cnt", match_cnt, 1);

    // Reset mid-stream.
    send(16'b1101, 4, p);
    do_reset();
    bit_in(1);
    chk("post_rst_out", out, 0);

    // Length 0 clamps to 1.
    load(8'h01, 4'd0, 1'b1, 1'b1);
    send(16'b111, 3, p);
    chk("len0_pulses", p, 16'h0007);

    // Length 15 clamps to 8.
    load(8'hA5, 4'd15, 1'b1, 1'b1);
    send(16'h00A5, 8, p);
    chk("len15_pulses", p, 16'h0080);

    // Load on the same edge as the final bit.
    load(8'h1B, 4'd5, 1'b1, 1'b1);
    send(16'b1101, 4, p);
    step(1'b1, 1'b1, 1'b1, 8'h1B, 4'd5, 1'b1, 1'b0);
    chk("load_final_out", out, 0);

    // Counter saturation, then clear with a coincident match.
    load(8'h01, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 256; i++) bit_in(1);
    chk("sat_cnt", match_cnt, 255);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    chk("clr_match_cnt", match_cnt, 1);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
        load(8'($urandom), rl, 1'($urandom), 1'($urandom));
      end else begin
        step(r < 80, 1'($urandom), 1'b0, 8'h00, 4'd0, 1'b0, r == 99);
      end
    end

    chk("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
